neuron_scheduler: RTL and testbench

NEURON_SCHEDULER -- requirements
Module: neuron_scheduler

---
 rtl/neuron_pkg.sv | 15 +
 rtl/lif_update.sv | 34 +++
 rtl/neuron_scheduler.sv | 166 ++++++++++++++++
 tb/tb_neuron_scheduler.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared FSM encoding and constants for the time-multiplexed LIF neuron scheduler.
package neuron_pkg;

   localparam int unsigned DEFAULT_THRESHOLD = 230;
   localparam int unsigned STEP_CNT_W        = 16;
   localparam int unsigned REFRACT_W         = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EMIT  = 2'd2,
      DONE  = 2'd3
   } sched_state_e;

endpackage

// File: rtl/lif_update.sv
// Combinational leaky-integrate-and-fire update shared by every virtual neuron:
// spike compare on the old state, 7/8 leak, saturating add of the input current.
module lif_update #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned THRESHOLD = 230
) (
   input  logic [WIDTH-1:0] state,
   input  logic [WIDTH-1:0] cur,
   output logic             spike,
   output logic [WIDTH-1:0] next_state
);

   localparam logic [WIDTH-1:0] THRESH  = WIDTH'(THRESHOLD);
   localparam logic [WIDTH+1:0] SAT_MAX = (WIDTH+2)'({WIDTH{1'b1}});

   logic [WIDTH+1:0] sum;

   // NOTE: every output gets a default assignment first so no path through
   // this block can leave a value unassigned and infer a latch.
   always_comb begin
      sum        = (WIDTH+2)'(cur)
                 + (WIDTH+2)'(state >> 1)
                 + (WIDTH+2)'(state >> 2)
                 + (WIDTH+2)'(state >> 3);
      spike      = (state >= THRESH);
      next_state = sum[WIDTH-1:0];
      if (spike) begin
         next_state = '0;
      end else if (sum > SAT_MAX) begin
         next_state = '1;
      end
   end

endmodule

// File: rtl/neuron_scheduler.sv
// Time-multiplexed LIF neuron scheduler: one shared update datapath walks all
// neurons per timestep. Optional refractory counters: define SCHED_REFRACTORY_EN.
module neuron_scheduler
   import neuron_pkg::*;
#(
   parameter int unsigned N_NEURONS = 4,
   parameter int unsigned WIDTH     = 8,
`ifdef SCHED_REFRACTORY_EN
   parameter logic [REFRACT_W-1:0] REFRACT_STEPS = 4'd2,
`endif
   parameter int unsigned THRESHOLD = DEFAULT_THRESHOLD
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         cur_valid,
   output logic                         cur_ready,
   input  logic [WIDTH-1:0]             cur_data,
   output logic                         spk_valid,
   input  logic                         spk_ready,
   output logic [$clog2(N_NEURONS)-1:0] spk_id,
   output logic                         busy,
   output logic                         done,
   output logic [STEP_CNT_W-1:0]        step_count,
   input  logic [$clog2(N_NEURONS)-1:0] dbg_sel,
   output logic [WIDTH-1:0]             dbg_state
);

   localparam int unsigned      IDX_W    = $clog2(N_NEURONS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);
   localparam logic [IDX_W:0]   N_COUNT  = (IDX_W+1)'(N_NEURONS);

   sched_state_e     st;
   logic [IDX_W-1:0] idx;
   logic [WIDTH-1:0] state_mem [N_NEURONS];

   logic             fire;
   logic             last;
   logic             lif_spike;
   logic [WIDTH-1:0] lif_next;
   logic             in_refract;
   logic             spike_eff;
   logic [WIDTH-1:0] commit_state;

   assign fire = (st == FETCH) && cur_valid && cur_ready;
   assign last = (idx == LAST_IDX);

   lif_update #(
      .WIDTH     (WIDTH),
      .THRESHOLD (THRESHOLD)
   ) u_lif (
      .state      (state_mem[idx]),
      .cur        (cur_data),
      .spike      (lif_spike),
      .next_state (lif_next)
   );

`ifdef SCHED_REFRACTORY_EN
   logic [REFRACT_W-1:0] refr_cnt [N_NEURONS];

   assign in_refract = (refr_cnt[idx] != '0);

   // A refractory neuron still consumes its current but neither integrates nor fires.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_NEURONS; i++) begin
            refr_cnt[i] <= '0;
         end
      end else if (fire) begin
         if (in_refract) begin
            refr_cnt[idx] <= refr_cnt[idx] - 1'b1;
         end else if (lif_spike) begin
            refr_cnt[idx] <= REFRACT_STEPS;
         end
      end
   end
`else
   assign in_refract = 1'b0;
`endif

   assign spike_eff    = lif_spike && !in_refract;
   assign commit_state = in_refract ? '0 : lif_next;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         st         <= IDLE;
         idx        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         cur_ready  <= 1'b0;
         spk_valid  <= 1'b0;
         spk_id     <= '0;
         step_count <= '0;
         // NOTE: the membrane array is reset explicitly; a fresh run must start
         // every neuron from rest, not from whatever the flops powered up with.
         for (int i = 0; i < N_NEURONS; i++) begin
            state_mem[i] <= '0;
         end
      end else begin
         done <= 1'b0;
         unique case (st)
            IDLE: begin
               if (start) begin
                  st        <= FETCH;
                  idx       <= '0;
                  busy      <= 1'b1;
                  cur_ready <= 1'b1;
               end
            end

            FETCH: begin
               if (fire) begin
                  state_mem[idx] <= commit_state;
                  if (spike_eff) begin
                     st        <= EMIT;
                     spk_valid <= 1'b1;
                     spk_id    <= idx;
                     cur_ready <= 1'b0;
                  end else if (!last) begin
                     idx <= idx + 1'b1;
                  end else begin
                     st        <= DONE;
                     cur_ready <= 1'b0;
                     done      <= 1'b1;
                  end
               end
            end

            EMIT: begin
               if (spk_ready) begin
                  spk_valid <= 1'b0;
                  if (!last) begin
                     st        <= FETCH;
                     idx       <= idx + 1'b1;
                     cur_ready <= 1'b1;
                  end else begin
                     st   <= DONE;
                     done <= 1'b1;
                  end
               end
            end

            DONE: begin
               st         <= IDLE;
               busy       <= 1'b0;
               step_count <= step_count + 1'b1;
            end

            default: begin
               st <= IDLE;
            end
         endcase
      end
   end

   // Non-power-of-two neuron counts leave unused dbg_sel codes; those read as zero.
   always_comb begin
      dbg_state = '0;
      if ({1'b0, dbg_sel} < N_COUNT) begin
         dbg_state = state_mem[dbg_sel];
      end
   end

endmodule

// File: tb/tb_neuron_scheduler.sv
// Self-checking bench for neuron_scheduler: a timestep-level model predicts
// final membrane states and the ordered spike stream; directed steps pin it.
module tb_neuron_scheduler;

   localparam int N   = 4;
   localparam int THR = 230;

   logic        clk;
   logic        rst;
   logic        start;
   logic        cur_valid;
   logic        cur_ready;
   logic [7:0]  cur_data;
   logic        spk_valid;
   logic        spk_ready;
   logic [1:0]  spk_id;
   logic        busy;
   logic        done;
   logic [15:0] step_count;
   logic [1:0]  dbg_sel;
   logic [7:0]  dbg_state;

   neuron_scheduler #(
      .N_NEURONS (N),
      .WIDTH     (8),
      .THRESHOLD (THR)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .cur_valid  (cur_valid),
      .cur_ready  (cur_ready),
      .cur_data   (cur_data),
      .spk_valid  (spk_valid),
      .spk_ready  (spk_ready),
      .spk_id     (spk_id),
      .busy       (busy),
      .done       (done),
      .step_count (step_count),
      .dbg_sel    (dbg_sel),
      .dbg_state  (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;
   bit checking = 1'b0;

   int exp_state [N];
   int exp_spk [$];
   int exp_steps   = 0;
   int done_seen   = 0;
   int last_spk_id = -1;
`ifdef SCHED_REFRACTORY_EN
   int exp_refr [N];
`endif

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // One whole timestep computed from the neuron rules, not cycle by cycle.
   function automatic void model_predict(input int cur [N]);
      for (int i = 0; i < N; i++) begin
         int s;
         int t;
         s = exp_state[i];
`ifdef SCHED_REFRACTORY_EN
         if (exp_refr[i] > 0) begin
            exp_refr[i]--;
            exp_state[i] = 0;
            continue;
         end
`endif
         if (s >= THR) begin
            exp_state[i] = 0;
            exp_spk.push_back(i);
`ifdef SCHED_REFRACTORY_EN
            exp_refr[i] = 2;
`endif
         end else begin
            t = cur[i] + s / 2 + s / 4 + s / 8;
            exp_state[i] = (t > 255) ? 255 : t;
         end
      end
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < N; i++) begin
         exp_state[i] = 0;
`ifdef SCHED_REFRACTORY_EN
         exp_refr[i] = 0;
`endif
      end
      exp_spk.delete();
      exp_steps = 0;
   endfunction

   task automatic peek(input int i, output int v);
      dbg_sel = 2'(i);
      #1;
      v = int'(dbg_state);
   endtask

   task automatic check_states(input string tag);
      int v;
      for (int i = 0; i < N; i++) begin
         peek(i, v);
         check($sformatf("%s_state%0d", tag, i), v, exp_state[i]);
      end
   endtask

   task automatic do_reset(input string tag);
      @(posedge clk); #2;
      rst       = 1'b1;
      start     = 1'b0;
      cur_valid = 1'b0;
      cur_data  = 8'd0;
      spk_ready = 1'b1;
      @(posedge clk); #2;
      model_clear();
      check({tag, "_quiet"}, {busy, done, cur_ready, spk_valid}, 0);
      check({tag, "_step_count"}, step_count, 0);
      check_states(tag);
      rst = 1'b0;
   endtask

   // Drives one timestep: currents c0..c3, optional cur_valid gap before
   // handshake gap_at, spk_ready held low for `stall` cycles per spike.
   task automatic run_step(input int c0, input int c1, input int c2, input int c3,
                           input int gap_at, input int gap_len, input int stall,
                           input int exp_lat, input string tag);
      int  cur [N];
      int  k;
      int  gl;
      int  sl;
      int  lat;
      bit  fire;
      bit  acc;
      bit  seen;
      cur[0] = c0; cur[1] = c1; cur[2] = c2; cur[3] = c3;
      k = 0; gl = gap_len; sl = stall; lat = 0; seen = 1'b0;
      model_predict(cur);
      @(posedge clk); #2;
      start = 1'b1;
      while (!seen && lat < 200) begin
         cur_data = 8'(cur[(k < N) ? k : N - 1]);
         if (k == gap_at && gl > 0) begin
            cur_valid = 1'b0;
            gl--;
            check({tag, "_gap_waits_in_fetch"}, {busy, cur_ready}, 2'b11);
         end else begin
            cur_valid = 1'b1;
         end
         if (spk_valid && sl > 0) begin
            spk_ready = 1'b0;
            sl--;
            check({tag, "_stall_cur_ready"}, cur_ready, 0);
         end else begin
            spk_ready = 1'b1;
         end
         fire = cur_valid && cur_ready;
         acc  = spk_valid && spk_ready;
         if (acc) last_spk_id = int'(spk_id);
         @(posedge clk); #2;
         start = 1'b0;
         lat++;
         if (fire) k++;
         if (acc) sl = stall;
         seen = done;
      end
      if (!seen) check({tag, "_done_timeout"}, seen, 1);
      else       check({tag, "_latency"}, lat, exp_lat);
      cur_valid = 1'b0;
      spk_ready = 1'b1;
      @(posedge clk); #2;
      check_states(tag);
   endtask

   task automatic reset_in_emit();
      int lat;
      int d0;
      lat = 0;
      @(posedge clk); #2;
      start     = 1'b1;
      cur_valid = 1'b1;
      cur_data  = 8'd0;
      spk_ready = 1'b0;
      while (!spk_valid && lat < 20) begin
         @(posedge clk); #2;
         start = 1'b0;
         lat++;
      end
      start = 1'b0;
      check("rst_emit_reached", spk_valid, 1);
      check("rst_emit_id", spk_id, 2);
      d0  = done_seen;
      rst = 1'b1;
      @(posedge clk); #2;
      model_clear();
      check("rst_emit_quiet", {spk_valid, busy, cur_ready, done}, 0);
      check("rst_emit_step_count", step_count, 0);
      check_states("rst_emit");
      rst       = 1'b0;
      cur_valid = 1'b0;
      spk_ready = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      check("rst_emit_no_done", done_seen, d0);
   endtask

   // Compare process: protocol rules and model-predicted spikes/counts every cycle.
   initial begin : compare
      logic       p_valid;
      logic       p_ready;
      logic       p_done;
      logic       p_rst;
      logic [1:0] p_id;
      p_valid = 1'b0; p_ready = 1'b0; p_done = 1'b0; p_rst = 1'b1; p_id = '0;
      forever begin
         @(negedge clk);
         if (checking) begin
            check("cur_ready_and_spk_valid", cur_ready & spk_valid, 0);
            if (!busy) check("idle_outputs_low", {cur_ready, spk_valid, done}, 0);
            if (p_done) check("after_done_idle", {done, busy}, 0);
            if (!p_rst && !rst) begin
               if (p_valid && !p_ready) begin
                  check("spk_valid_held", spk_valid, 1);
                  check("spk_id_held", spk_id, p_id);
               end
               if (p_valid && p_ready) check("spk_valid_drops", spk_valid, 0);
            end
            if (spk_valid && spk_ready && !rst) begin
               if (exp_spk.size() == 0) check("spk_expected_pending", exp_spk.size(), 1);
               else                     check("spk_id", spk_id, exp_spk.pop_front());
            end
            if (done) begin
               check("step_count_at_done", step_count, exp_steps);
               check("spk_all_emitted", exp_spk.size(), 0);
               exp_steps = (exp_steps + 1) & 16'hFFFF;
               done_seen++;
            end
         end
         p_valid = spk_valid;
         p_ready = spk_ready;
         p_done  = done;
         p_rst   = rst;
         p_id    = spk_id;
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int v;
      rst = 1'b1; start = 1'b0; cur_valid = 1'b0; cur_data = 8'd0;
      spk_ready = 1'b1; dbg_sel = 2'd0;
      model_clear();
      do_reset("init_rst");
      checking = 1'b1;

      // Four neurons at 100, no spikes: done five cycles after start.
      run_step(100, 100, 100, 100, -1, 0, 0, 5, "a");
      for (int i = 0; i < N; i++) begin
         peek(i, v);
         check($sformatf("a_lit_state%0d", i), v, 100);
      end
      check("a_lit_step_count", step_count, 1);

      // Neuron 2 at 200 per step: 200, saturate to 255, then spike.
      do_reset("b_rst");
      run_step(0, 0, 200, 0, -1, 0, 0, 5, "b1");
      peek(2, v); check("b1_lit_n2", v, 200);
      run_step(0, 0, 200, 0, -1, 0, 0, 5, "b2");
      peek(2, v); check("b2_lit_n2", v, 255);
      run_step(0, 0, 200, 0, -1, 0, 0, 6, "b3");
      peek(2, v); check("b3_lit_n2", v, 0);
      check("b3_lit_spk_id", last_spk_id, 2);
      check("b3_lit_step_count", step_count, 3);

      // Spike with spk_ready held low for three cycles.
      run_step(250, 0, 0, 0, -1, 0, 0, 5, "c1");
      run_step(0, 0, 0, 0, -1, 0, 3, 9, "c2");
      check("c2_lit_spk_id", last_spk_id, 0);

      // cur_valid dropped for three cycles before neuron 2.
      run_step(10, 20, 30, 40, 2, 3, 0, 8, "d");
      peek(3, v); check("d_lit_n3", v, 40);

      // Mixed currents, then two spikes including the last neuron.
      run_step(240, 5, 0, 255, -1, 0, 0, 5, "e1");
      peek(0, v); check("e1_lit_n0", v, 248);
      run_step(0, 0, 0, 0, -1, 0, 1, 9, "e2");
      check("e2_lit_spk_id", last_spk_id, 3);
      peek(1, v); check("e2_lit_n1", v, 18);
      run_step(0, 0, 240, 0, -1, 0, 0, 5, "e3");

      // Reset while a spike waits in EMIT, then a fresh step.
      reset_in_emit();
      run_step(100, 100, 100, 100, -1, 0, 0, 5, "post_rst");
      check("post_rst_lit_step_count", step_count, 1);

      // Neuron 0 spikes, then is driven at 255 on following steps.
      run_step(240, 0, 0, 0, -1, 0, 0, 5, "r1");
      run_step(255, 0, 0, 0, -1, 0, 0, 6, "r2");
      check("r2_lit_spk_id", last_spk_id, 0);
`ifdef SCHED_REFRACTORY_EN
      run_step(255, 0, 0, 0, -1, 0, 0, 5, "r3");
      peek(0, v); check("r3_lit_n0", v, 0);
      run_step(255, 0, 0, 0, -1, 0, 0, 5, "r4");
      peek(0, v); check("r4_lit_n0", v, 0);
`else
      run_step(255, 0, 0, 0, -1, 0, 0, 5, "r3");
      peek(0, v); check("r3_lit_n0", v, 255);
      run_step(255, 0, 0, 0, -1, 0, 0, 6, "r4");
      peek(0, v); check("r4_lit_n0", v, 0);
`endif
      run_step(255, 0, 0, 0, -1, 0, 0, 5, "r5");
      peek(0, v); check("r5_lit_n0", v, 255);

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
